// File: rtl/fp_add_issuer.sv
// fp_add_issuer
//   Request-side front end for a multi-cycle FP adder. Operand pairs arrive on a
//   valid/ready port and are queued in a small FIFO. One pair at a time is issued
//   to the adder as a single-cycle fpa_data_valid pulse with fpa_a/fpa_b held
//   stable. The adder's fixed latency is waited out, then fpa_sum/fpa_error are
//   captured and returned in request order on a valid/ready response port.
//
//   Handshake rule: a transfer happens on a rising clk edge where valid and ready
//   are both 1. A source holds valid and payload until that edge. The sink may
//   drive ready whenever it likes.
//
// Parameters
//   DEPTH    operand-pair FIFO entries (power of 2, >= 2)
//   RES_LAT  cycles from the fpa_data_valid cycle to the fpa_sum/fpa_error sample
//            cycle (>= 2)
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/req_ready        operand pair handshake, req_ready = !full
//   req_a/req_b                operand pair (IEEE-754 single)
//   rsp_valid/rsp_ready        result handshake
//   rsp_sum/rsp_error          captured adder result
//   fpa_a/fpa_b                adder operands
//   fpa_data_valid             adder start pulse
//   fpa_sum/fpa_error          adder result inputs
//   busy                       FSM not idle or FIFO not empty
//   err_count                  count of error responses handed over
//
// Build option
//   FPA_ISSUE_ERRCNT_EN : when defined, err_count counts rsp handshakes that carry
//   rsp_error=1, saturating at 16'hFFFF. When undefined, err_count is tied to 0.

module fp_add_issuer #(
  parameter int DEPTH   = 4,
  parameter int RES_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_sum,
  output logic        rsp_error,
  output logic [31:0] fpa_a,
  output logic [31:0] fpa_b,
  output logic        fpa_data_valid,
  input  logic [31:0] fpa_sum,
  input  logic        fpa_error,
  output logic        busy,
  output logic [15:0] err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(RES_LAT) + 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, HOLD} state_t;

  state_t        state, state_next;

  logic [31:0]   mem_a [DEPTH];
  logic [31:0]   mem_b [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;
  logic [LW-1:0] wait_cnt;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign push      = req_valid && !full;
  assign pop       = (state == ISSUE);
  assign req_ready = !full;
  assign busy      = (state != IDLE) || !empty;

  // FIFO storage carries no reset; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= req_a;
      mem_b[wr_ptr] <= req_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!empty) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      // wait_cnt is loaded with RES_LAT-1 in ISSUE; leaving WAIT when it reads 1
      // puts CAPTURE exactly RES_LAT cycles after the start pulse.
      WAIT:    if (wait_cnt <= LW'(1)) state_next = CAPTURE;
      CAPTURE: state_next = HOLD;
      HOLD:    if (rsp_ready) state_next = empty ? IDLE : ISSUE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpa_a          <= '0;
      fpa_b          <= '0;
      fpa_data_valid <= 1'b0;
      wait_cnt       <= '0;
      rsp_valid      <= 1'b0;
      rsp_sum        <= '0;
      rsp_error      <= 1'b0;
    end else begin
      // Operands and the start pulse are registered on entry to ISSUE, so both
      // are valid together for the whole ISSUE cycle and the operands then stay
      // untouched until the next entry to ISSUE.
      fpa_data_valid <= (state_next == ISSUE);
      if (state_next == ISSUE) begin
        fpa_a <= mem_a[rd_ptr];
        fpa_b <= mem_b[rd_ptr];
      end
      case (state)
        ISSUE:   wait_cnt <= LW'(RES_LAT - 1);
        WAIT:    wait_cnt <= wait_cnt - LW'(1);
        CAPTURE: begin
          rsp_sum   <= fpa_sum;
          rsp_error <= fpa_error;
          rsp_valid <= 1'b1;
        end
        HOLD:    if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef FPA_ISSUE_ERRCNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (rsp_valid && rsp_ready && rsp_error && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 16'h0;
`endif

endmodule

// File: tb/tb_fp_add_issuer.sv
// tb_fp_add_issuer
//   Bench for fp_add_issuer. A behavioural adder stand-in answers the start
//   pulse: it shows the true result only in the cycle RES_LAT after the pulse and
//   junk otherwise, so a capture in the wrong cycle is visible. The expected
//   response stream is computed from accepted requests with a plain arithmetic
//   float-add model and kept in an ordered queue.

module tb_fp_add_issuer;

  localparam int DEPTH   = 4;
  localparam int RES_LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_sum;
  logic        rsp_error;
  logic [31:0] fpa_a, fpa_b;
  logic        fpa_data_valid;
  logic [31:0] fpa_sum;
  logic        fpa_error;
  logic        busy;
  logic [15:0] err_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  fp_add_issuer #(.DEPTH(DEPTH), .RES_LAT(RES_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_error(rsp_error),
    .fpa_a(fpa_a), .fpa_b(fpa_b), .fpa_data_valid(fpa_data_valid),
    .fpa_sum(fpa_sum), .fpa_error(fpa_error),
    .busy(busy), .err_count(err_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Returns {error, sum}. Any operand with exponent 0xFF is an error with sum
  // 7FFFFFFF. Otherwise align, add or subtract magnitudes, renormalise, truncate.
  function automatic logic [32:0] model_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    int          ex, ey, e;
    longint      mx, my, m;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {1'b1, 32'h7FFF_FFFF};
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else begin x = b; y = a; end
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = longint'({1'b1, x[22:0]});
    my = longint'({1'b1, y[22:0]});
    if (ex - ey > 31) my = 0;
    else my = my >> (ex - ey);
    e = ex;
    if (x[31] == y[31]) m = mx + my;
    else m = mx - my;
    if (m == 0) return 33'h0;
    if (m >= (longint'(1) << 24)) begin m = m >> 1; e++; end
    while (m < (longint'(1) << 23)) begin m = m << 1; e--; end
    return {1'b0, x[31], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0] e;
    logic [31:0] f;
    e = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(100, 150));
    f = $urandom;
    return {1'($urandom_range(0, 1)), e, f[22:0]};
  endfunction

  // ---------------- adder stand-in ----------------
  logic [RES_LAT-1:0] dv_pipe;
  logic [31:0]        ha, hb;
  logic [32:0]        hres;

  always @(posedge clk) begin
    if (rst) dv_pipe <= '0;
    else     dv_pipe <= {dv_pipe[RES_LAT-2:0], fpa_data_valid};
    if (fpa_data_valid) begin
      ha   <= fpa_a;
      hb   <= fpa_b;
      hres <= model_add(fpa_a, fpa_b);
    end
  end

  assign fpa_sum   = dv_pipe[RES_LAT-1] ? hres[31:0] : 32'hDEAD_BEEF;
  assign fpa_error = dv_pipe[RES_LAT-1] ? hres[32]   : 1'b1;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [32:0] exp_q[$];
  logic [63:0] iss_q[$];
  int          last_acc_cyc = 0;
  int          last_dv      = 0;
  bit          have_dv      = 0;
  int          exp_errs     = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      iss_q.delete();
      have_dv  <= 0;
      exp_errs <= 0;
    end else begin
      if (req_valid && req_ready) begin
        last_acc_cyc <= cyc;
        exp_q.push_back(model_add(req_a, req_b));
        iss_q.push_back({req_a, req_b});
      end
      if (fpa_data_valid) begin
        if (have_dv) check("dv_gap_ok", 64'(cyc - last_dv >= RES_LAT + 2), 1);
        have_dv <= 1;
        last_dv <= cyc;
        if (iss_q.size() == 0) check("dv_unexpected", fpa_data_valid, 0);
        else check("issue_ops", {fpa_a, fpa_b}, iss_q.pop_front());
      end
      if (dv_pipe[RES_LAT-1]) check("ops_stable", {fpa_a, fpa_b}, {ha, hb});
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 0);
        end else begin
          check("rsp_data", {rsp_error, rsp_sum}, exp_q[0]);
          if (exp_q[0][32]) exp_errs <= exp_errs + 1;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  function automatic int exp_err_count();
`ifdef FPA_ISSUE_ERRCNT_EN
    return exp_errs;
`else
    return 0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    while (!req_ready && n < 2000) begin @(negedge clk); n++; end
    if (!req_ready) check("send_timeout", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int at);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    check("rsp_timeout", rsp_valid, 1);
    at = cyc;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin @(negedge clk); n++; end
    check("drain_busy", busy, 0);
    check("drain_left", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  int  at;
  int  seen;
  bit  done;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_dv", fpa_data_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err_count", err_count, 0);
    check("rst_fpa_ops", {fpa_a, fpa_b}, 0);
    check("rst_rsp_data", {rsp_error, rsp_sum}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1.0 + 2.0 with rsp_ready held high: value and latency
    rsp_ready = 1'b1;
    send(32'h3F80_0000, 32'h4000_0000);
    wait_rsp(at);
    check("latency", at - last_acc_cyc, RES_LAT + 3);
    check("sum_1p2", {rsp_error, rsp_sum}, {1'b0, 32'h4040_0000});
    wait_drain();

    // NaN operand -> error response
    send(32'h7FC0_0000, 32'h3F80_0000);
    wait_rsp(at);
    check("nan_rsp", {rsp_error, rsp_sum}, {1'b1, 32'h7FFF_FFFF});
    wait_drain();
    check("err_count_nan", err_count, exp_err_count());

    // DEPTH+1 back-to-back with responses blocked: FIFO fills, then all drain in order
    rsp_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) send(rand_op(), rand_op());
    repeat (3) @(negedge clk);
    check("full_req_ready", req_ready, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_drain();

    // Push and pop in the same cycle with DEPTH-1 entries queued
    rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(rand_op(), rand_op());
    wait_rsp(at);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_a     = rand_op();
    req_b     = rand_op();
    @(negedge clk);
    check("pp_dv", fpa_data_valid, 1);
    check("pp_req_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("pp_ready_after", req_ready, 1);
    @(posedge clk); #1;
    send(rand_op(), rand_op());
    @(negedge clk);
    check("pp_full", req_ready, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_drain();

    // Random stream with random request gaps and response back-pressure
    done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          send(rand_op(), rand_op());
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    rsp_ready = 1'b1;
    wait_drain();
    check("err_count_stream", err_count, exp_err_count());

    // Reset while waiting on the adder: everything discarded, no stale response
    send(32'h4000_0000, 32'h4040_0000);
    begin
      int n = 0;
      @(negedge clk);
      while (!fpa_data_valid && n < 100) begin @(negedge clk); n++; end
      check("wait_dv_seen", fpa_data_valid, 1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_dv", fpa_data_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_req_ready", req_ready, 1);
    check("midrst_err_count", err_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("stale_rsp", seen, 0);
    @(posedge clk); #1;

    // Normal traffic after the reset
    send(32'h3F80_0000, 32'hBF00_0000);
    wait_rsp(at);
    check("post_rst_rsp", {rsp_error, rsp_sum}, {1'b0, 32'h3F00_0000});
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
